muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the architectural HI and LO registers of the pipelined MIPS core. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the execute stage and computes multi-cycle products and quotients with a shift-add or restore loop. It drives the `hi`/`lo` values that the ALU reads for MFHI/MFLO, and it raises `busy` so the hazard unit can stall dependent instructions.

## Interface

- `WIDTH`, 32, operand and HI/LO register width; the iteration count equals `WIDTH`.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request strobe; sampled on each rising edge.
- `op`  input  3  request code:
  - 0 MULTU, 1 DIVU, 2 MULT, 3 DIV, 4 MTHI, 5 MTLO.
  - 6 and 7 are ignored.
- `a`  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  input  WIDTH  rt operand: multiplier or divisor.
- `busy`  output  1  high while an iteration is in progress.
- `done`  output  1  one-cycle pulse; the new `hi`/`lo` are valid in this cycle.
- `div_by_zero`  output  1  qualified by `done`; high when the completed DIV/DIVU had `b==0`.
- `hi`  output  WIDTH  HI register; feeds the ALU `hi` input.
- `lo`  output  WIDTH  LO register; feeds the ALU `lo` input.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
  - IDLE or DONE, with `start` and `op` in 0–3 → RUN; operands are latched and the 5-bit counter is cleared.
  - IDLE or DONE, with `start` and `op` 4/5 → `hi<=a` (op 4) or `lo<=a` (op 5) at that edge. The next state is IDLE and no `done` pulse is issued.
  - RUN → RUN while counter < WIDTH-1. At counter == WIDTH-1, `{hi,lo}` are written and the state goes to DONE.
  - DONE → IDLE unless a new `start` is accepted in the same cycle.
- `start` is ignored while in RUN; the request is not queued.
- Multiply:
  - The unit works on operand magnitudes with a 2*WIDTH accumulator, one multiplier bit per cycle.
  - The product is negated at completion when the operands have opposite signs (MULT only).
  - `hi` receives the upper WIDTH bits and `lo` the lower WIDTH bits.
- Divide:
  - The unit uses restoring division on magnitudes, one quotient bit per cycle.
  - `lo` receives the quotient, truncated toward zero.
  - `hi` receives the remainder, which takes the sign of the dividend (DIV).
- Divide by zero (signed or unsigned):
  - `lo = {WIDTH{1}}` and `hi = a` (original value).
  - `div_by_zero = 1` during the DONE cycle.
  - The unit still takes the full WIDTH cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `lo = 0x80000000`, `hi = 0`. No flag is raised.
- `hi`/`lo` hold their values in all states except at the write edges listed above. Partial results are never visible.

## Timing

- Reset (asynchronous, `reset==0`):
  - State = IDLE, counter = 0.
  - `hi = lo = 0`; `busy = done = div_by_zero = 0`.
  - Takes effect immediately, including mid-RUN. Any in-flight operation is discarded.
- Latency for MULT/MULTU/DIV/DIVU:
  - `start` is sampled at edge E0.
  - `busy = 1` for cycles 1..WIDTH.
  - `hi`/`lo` update at edge E(WIDTH).
  - `done = 1` in cycle WIDTH+1, which is 33 cycles after the request for WIDTH=32.
- MTHI/MTLO: the new value is visible on `hi`/`lo` in the cycle after the `start` edge.
- Back-to-back: a `start` during the DONE cycle is accepted. `busy` then rises in the next cycle with no idle gap.
- `busy` and `done` are never high in the same cycle.
- All outputs are driven directly from registers, with no combinational path from inputs.

## Configuration

- `MULDIV_SIGNED_EN`
  - Defined: ops 2 (MULT) and 3 (DIV) use two's-complement sign handling as described under Operation.
  - Undefined: the sign-handling logic is not built, and ops 2/3 behave exactly like ops 0/1 (unsigned).

## Test plan

- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → `done` 33 cycles after `start`; `hi=0xFFFFFFFE`, `lo=0x00000001`; `busy` high for exactly 32 cycles.
- With `MULDIV_SIGNED_EN`:
  - MULT `a=-3` (0xFFFFFFFD), `b=5` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`.
  - DIV `a=-7`, `b=2` → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - Without the macro, the same DIV → `lo=0x7FFFFFFC`, `hi=0x00000001`.
- DIVU `a=100`, `b=0` → `lo=0xFFFFFFFF`, `hi=0x00000064`, `div_by_zero=1` only in the `done` cycle.
- MTHI `a=0x12345678`, then DIVU 9/4 started in cycle 2 with `start` re-asserted (MTLO 0xDEAD) mid-run:
  - `hi=0x12345678` from cycle 1.
  - The MTLO is ignored.
  - Final `lo=2`, `hi=1`.
- Start MULTU 7*6, assert `reset=0` at cycle 10 → outputs all 0 immediately. After release, `done` never pulses, and a fresh MULTU 7*6 yields `lo=42`, `hi=0`.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one result bit per cycle.
// MULDIV_SIGNED_EN builds signed handling for ops 2/3; otherwise they run unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_step, prod;
  logic [WIDTH-1:0]   opb_reg, a_reg, hi_reg, lo_reg, hi_next, lo_next;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic               is_div_reg, neg_q_reg, neg_r_reg, divz_reg;
  logic               busy_reg, done_reg, dbz_reg;
  logic               accept_op, accept_mt, last;
  logic               a_neg, b_neg;

`ifdef MULDIV_SIGNED_EN
  assign a_neg = bus.op[1] & bus.a[WIDTH-1];
  assign b_neg = bus.op[1] & bus.b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  always_comb begin
    state_next = state_reg;
    accept_op  = 1'b0;
    accept_mt  = 1'b0;
    last       = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start && !bus.op[2]) begin
          accept_op  = 1'b1;
          state_next = RUN;
        end else if (bus.start && (bus.op == 3'd4 || bus.op == 3'd5)) begin
          accept_mt = 1'b1;
        end
      end
      RUN:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opb_reg};
    if (!is_div_reg)
      acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    quot = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
    prod = neg_q_reg ? -acc_step : acc_step;
    if (!is_div_reg) begin
      hi_next = prod[2*WIDTH-1:WIDTH];
      lo_next = prod[WIDTH-1:0];
    end else if (divz_reg) begin
      hi_next = a_reg;
      lo_next = '1;
    end else begin
      hi_next = neg_r_reg ? -rem : rem;
      lo_next = neg_q_reg ? -quot : quot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      a_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      divz_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= last;
      dbz_reg   <= last & divz_reg;
      if (accept_op) begin
        cnt_reg    <= '0;
        is_div_reg <= bus.op[0];
        neg_q_reg  <= a_neg ^ b_neg;
        neg_r_reg  <= a_neg;
        divz_reg   <= bus.op[0] && (bus.b == '0);
        a_reg      <= bus.a;
        opb_reg    <= bus.op[0] ? b_mag : a_mag;
        acc_reg    <= bus.op[0] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + CW'(1);
        acc_reg <= acc_step;
      end
      if (last) begin
        hi_reg <= hi_next;
        lo_reg <= lo_next;
      end else if (accept_mt) begin
        if (bus.op[0]) lo_reg <= bus.a;
        else           hi_reg <= bus.a;
      end
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand sequences, random ops vs. arithmetic model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Result as defined by the instruction set, computed with plain wide arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    longint sa, sb, q, r;
    logic sgn;
`ifdef MULDIV_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!op[0]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a; l = 32'hFFFFFFFF; dz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        l = 32'h80000000; h = 32'h0;
      end else begin
        q = sa / sb; r = sa % sb;
        l = 32'(q); h = 32'(r);
      end
    end else begin
      l = a / b; h = a % b;
    end
  endtask

  // Issues a MULT/DIV in the current cycle and returns in the done cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eh, el;
    logic ed;
    int lat = 0, bcnt = 0, bad_overlap = 0, bad_dbz = 0, bad_hold = 0;
    logic first_busy = 1'b0;
    model(op, a, b, eh, el, ed);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (lat == 1) first_busy = bus.busy;
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) bad_overlap++;
      if (!bus.done && bus.div_by_zero) bad_dbz++;
      if (!bus.done && (bus.hi !== mdl_hi || bus.lo !== mdl_lo)) bad_hold++;
    end while (!bus.done && lat < 100);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b latency=%0d busy_cycles=%0d",
             op, a, b, bus.hi, bus.lo, bus.div_by_zero, lat, bcnt);
    check({name, "_latency"}, lat, 33);
    check({name, "_busy_cycles"}, bcnt, 32);
    check({name, "_busy_first"}, first_busy, 1);
    check({name, "_busy_done_overlap"}, bad_overlap, 0);
    check({name, "_dbz_unqualified"}, bad_dbz, 0);
    check({name, "_hold_during_run"}, bad_hold, 0);
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
    check({name, "_dbz"}, bus.div_by_zero, ed);
    mdl_hi = eh;
    mdl_lo = el;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    if (op == 3'd4) mdl_hi = a;
    if (op == 3'd5) mdl_lo = a;
    $display("op=%0d a=%h -> hi=%h lo=%h busy=%0b done=%0b", op, a, bus.hi, bus.lo, bus.busy, bus.done);
    check("mt_hi", bus.hi, mdl_hi);
    check("mt_lo", bus.lo, mdl_lo);
    check("mt_no_busy", bus.busy, 0);
    check("mt_no_done", bus.done, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bad, dpulse;
    logic [31:0] ra, rb;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

    vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{3'd1, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{3'd1, 32'd9,        32'd4,        32'h1,        32'h2,        1'b0};
    vecs[3] = '{3'd0, 32'd7,        32'd6,        32'h0,        32'd42,       1'b0};
    vecs[4] = '{3'd1, 32'h12345678, 32'd1,        32'h0,        32'h12345678, 1'b0};
    vecs[5] = '{3'd3, 32'd7,        32'd0,        32'h7,        32'hFFFFFFFF, 1'b1};
`ifdef MULDIV_SIGNED_EN
    vecs[6] = '{3'd2, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[7] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
`else
    vecs[6] = '{3'd2, 32'hFFFFFFFD, 32'd5,        32'h4,        32'hFFFFFFF1, 1'b0};
    vecs[7] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h1,        32'h7FFFFFFC, 1'b0};
    vecs[8] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0};
`endif
    vecs[9] = '{3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_dbz", bus.div_by_zero, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed table; entries run back to back from the DONE cycle.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] eh, el;
      logic ed;
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      model(vecs[i].op, vecs[i].a, vecs[i].b, eh, el, ed);
      check($sformatf("vec%0d_table_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_table_lo", i), bus.lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_table_dbz", i), bus.div_by_zero, vecs[i].exp_dbz);
    end
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("dbz_clears", bus.div_by_zero, 0);
    repeat (2) @(negedge clk);

    // MTHI, then DIVU 9/4 with a MTLO request mid-run that must be dropped.
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
    @(negedge clk);
    check("mthi_visible", bus.hi, 32'h12345678);
    mdl_hi = 32'h12345678;
    bus.op = 3'd1; bus.a = 32'd9; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000DEAD;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_mid_run_busy", bus.busy, 1);
    lat = 0; bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.lo == 32'h0000DEAD) bad++;
      @(negedge clk);
      lat++;
    end
    $display("seq mthi/divu: hi=%h lo=%h after %0d more cycles", bus.hi, bus.lo, lat);
    check("mtlo_dropped", bad, 0);
    check("seq_done_seen", bus.done, 1);
    check("seq_lo", bus.lo, 2);
    check("seq_hi", bus.hi, 1);
    mdl_hi = 32'd1; mdl_lo = 32'd2;

    // Ops 6/7 must do nothing.
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'hCAFEF00D;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    $display("op=7 -> hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
    check("op7_busy", bus.busy, 0);
    check("op7_hi", bus.hi, mdl_hi);
    check("op7_lo", bus.lo, mdl_lo);

    // Asynchronous reset in the middle of a MULTU.
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("async reset mid-run: hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_dbz", bus.div_by_zero, 0);
    mdl_hi = '0; mdl_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    dpulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dpulse++;
    end
    check("arst_no_done", dpulse, 0);
    do_op(3'd0, 32'd7, 32'd6, "post_reset_multu");
    check("post_reset_lo42", bus.lo, 42);

    // Random mix of operations, some back to back, some with idle gaps.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_mt($urandom_range(0, 1) ? 3'd4 : 3'd5, $urandom);
      end else begin
        ra = pick();
        rb = pick();
        do_op(3'($urandom_range(0, 3)), ra, rb, $sformatf("rnd%0d", i));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
